// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one data-memory port between the core load/store path (core_*)
//   and an external master (ext_*, e.g. debug or DMA loader).
//   - Core has fixed priority; ext wins once it has been denied EXT_MAX_WAIT
//     consecutive arbitration cycles.
//   - A busy memory (mem_miss_i) locks the port to the chosen requester; the
//     access is replayed from hold registers until the memory accepts it.
//   - Load data returns one cycle after acceptance, only to the requester
//     that owned the access.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   core_req_i/we/be/addr/wdata    core request (held until core_gnt_o)
//   core_gnt_o, core_rvalid_o      core accept / core read data valid
//   core_rdata_o, core_stall_o     core read data / core pipeline stall
//   ext_req_i/we/be/addr/wdata     ext request, same handshake
//   ext_gnt_o, ext_rvalid_o        ext accept / ext read data valid
//   ext_rdata_o                    ext read data
//   mem_req_o/we/be/addr/wdata     memory request (be forced 0 on loads)
//   mem_rdata_i                    memory read data, cycle after accept
//   mem_miss_i                     memory busy, request not accepted
module dmem_port_arbiter #(
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,
    input  logic        ext_req_i,
    input  logic        ext_we_i,
    input  logic [3:0]  ext_be_i,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_wdata_i,
    output logic        ext_gnt_o,
    output logic        ext_rvalid_o,
    output logic [31:0] ext_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_miss_i
);

    localparam int CNT_W = $clog2(EXT_MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXT_MAX_WAIT);

    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              owner_ext_reg;          // 1 = ext owns the held access
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              hold_we_reg;
    logic [3:0]        hold_be_reg;
    logic [31:0]       hold_addr_reg;
    logic [31:0]       hold_wdata_reg;
    logic              core_rvalid_reg, ext_rvalid_reg;

    logic              ext_win;
    logic              sel_ext;
    logic              req_any;
    logic              accept;
    logic              latch_hold;
    logic              acc_we;
    logic [3:0]        acc_be;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;

    // Arbitration and datapath selection
    always_comb begin
        ext_win    = ext_req_i & ((wait_cnt_reg == CNT_MAX) | ~core_req_i);
        sel_ext    = 1'b0;
        req_any    = 1'b0;
        acc_we     = 1'b0;
        acc_be     = 4'b0;
        acc_addr   = 32'b0;
        acc_wdata  = 32'b0;
        state_next = state_reg;
        latch_hold = 1'b0;

        if (state_reg == IDLE) begin
            sel_ext = ext_win;
            req_any = core_req_i | ext_req_i;
            if (req_any) begin
                acc_we    = sel_ext ? ext_we_i    : core_we_i;
                acc_be    = sel_ext ? ext_be_i    : core_be_i;
                acc_addr  = sel_ext ? ext_addr_i  : core_addr_i;
                acc_wdata = sel_ext ? ext_wdata_i : core_wdata_i;
            end
            if (req_any && mem_miss_i) begin
                latch_hold = 1'b1;
                state_next = MISS;
            end
        end else begin
            // Locked: replay the held access regardless of new requests
            sel_ext   = owner_ext_reg;
            req_any   = 1'b1;
            acc_we    = hold_we_reg;
            acc_be    = hold_be_reg;
            acc_addr  = hold_addr_reg;
            acc_wdata = hold_wdata_reg;
            if (!mem_miss_i) begin
                state_next = IDLE;
            end
        end

        // Combinational outputs are held low while reset is asserted
        accept = rst_n & req_any & ~mem_miss_i;
    end

    assign mem_req_o   = rst_n & req_any;
    assign mem_we_o    = mem_req_o & acc_we;
    assign mem_addr_o  = mem_req_o ? acc_addr  : 32'b0;
    assign mem_wdata_o = mem_req_o ? acc_wdata : 32'b0;

    // Byte enables only meaningful for stores
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_be
            assign mem_be_o[gi] = mem_we_o & acc_be[gi];
        end
    endgenerate

    assign core_gnt_o   = accept & ~sel_ext;
    assign ext_gnt_o    = accept &  sel_ext;
    assign core_stall_o = rst_n & core_req_i & ~core_gnt_o;

    // Starvation counter only advances while arbitration actually happens
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (ext_gnt_o || !ext_req_i) begin
            wait_cnt_next = '0;
        end else if (state_reg == IDLE && wait_cnt_reg != CNT_MAX) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            owner_ext_reg   <= 1'b0;
            wait_cnt_reg    <= '0;
            hold_we_reg     <= 1'b0;
            hold_be_reg     <= 4'b0;
            hold_addr_reg   <= 32'b0;
            hold_wdata_reg  <= 32'b0;
            core_rvalid_reg <= 1'b0;
            ext_rvalid_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            core_rvalid_reg <= accept & ~sel_ext & ~acc_we;
            ext_rvalid_reg  <= accept &  sel_ext & ~acc_we;
            if (latch_hold) begin
                owner_ext_reg  <= sel_ext;
                hold_we_reg    <= acc_we;
                hold_be_reg    <= acc_be;
                hold_addr_reg  <= acc_addr;
                hold_wdata_reg <= acc_wdata;
            end
        end
    end

    // Memory read data is valid exactly in the rvalid cycle; route it to the owner only
    assign core_rvalid_o = core_rvalid_reg;
    assign ext_rvalid_o  = ext_rvalid_reg;
    assign core_rdata_o  = core_rvalid_reg ? mem_rdata_i : 32'b0;
    assign ext_rdata_o   = ext_rvalid_reg  ? mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req_i, core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_gnt_o, core_rvalid_o, core_stall_o;
    logic [31:0] core_rdata_o;
    logic        ext_req_i, ext_we_i;
    logic [3:0]  ext_be_i;
    logic [31:0] ext_addr_i, ext_wdata_i;
    logic        ext_gnt_o, ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_miss_i;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    dmem_port_arbiter #(.EXT_MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_stall_o(core_stall_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_be_i(ext_be_i),
        .ext_addr_i(ext_addr_i), .ext_wdata_i(ext_wdata_i),
        .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o), .ext_rdata_o(ext_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_miss_i(mem_miss_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; inputs change there
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_drive(input logic req, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        core_req_i = req; core_we_i = we; core_be_i = be;
        core_addr_i = addr; core_wdata_i = wdata;
    endtask

    task automatic ext_drive(input logic req, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata);
        ext_req_i = req; ext_we_i = we; ext_be_i = be;
        ext_addr_i = addr; ext_wdata_i = wdata;
    endtask

    initial begin
        rst_n = 1'b0;
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        ext_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_rdata_i = 32'h0;
        mem_miss_i  = 1'b0;

        // Reset state
        #12;
        check("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        check("rst_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Core load alone
        core_drive(1, 0, 4'hF, 32'h100, 32'h0);
        #2;
        check("lw_core_gnt", {31'b0, core_gnt_o}, 32'd1);
        check("lw_ext_gnt", {31'b0, ext_gnt_o}, 32'd0);
        check("lw_mem_req", {31'b0, mem_req_o}, 32'd1);
        check("lw_mem_addr", mem_addr_o, 32'h100);
        check("lw_mem_be_forced0", {28'b0, mem_be_o}, 32'd0);
        check("lw_stall", {31'b0, core_stall_o}, 32'd0);
        tick();
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_rdata_i = 32'hDEADBEEF;
        #2;
        check("lw_core_rvalid", {31'b0, core_rvalid_o}, 32'd1);
        check("lw_core_rdata", core_rdata_o, 32'hDEADBEEF);
        check("lw_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd0);
        check("lw_ext_rdata", ext_rdata_o, 32'd0);
        check("lw_idle_mem_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        check("lw_rvalid_1cyc", {31'b0, core_rvalid_o}, 32'd0);

        // Both request every cycle: ext wins every 5th cycle
        core_drive(1, 0, 4'hF, 32'h200, 32'h0);
        ext_drive(1, 0, 4'hF, 32'h300, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("starv%0d_core_gnt", i), {31'b0, core_gnt_o}, (i % 5 == 4) ? 32'd0 : 32'd1);
            check($sformatf("starv%0d_ext_gnt", i), {31'b0, ext_gnt_o}, (i % 5 == 4) ? 32'd1 : 32'd0);
            check($sformatf("starv%0d_addr", i), mem_addr_o, (i % 5 == 4) ? 32'h300 : 32'h200);
            tick();
        end
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        ext_drive(0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();

        // Core store with three miss cycles
        core_drive(1, 1, 4'b0011, 32'h400, 32'h12345678);
        for (int c = 0; c < 4; c++) begin
            mem_miss_i = (c < 3);
            if (c == 1) core_addr_i = 32'h0BAD;  // protocol error: held access must not move
            #2;
            check($sformatf("sw%0d_mem_req", c), {31'b0, mem_req_o}, 32'd1);
            check($sformatf("sw%0d_mem_we", c), {31'b0, mem_we_o}, 32'd1);
            check($sformatf("sw%0d_mem_be", c), {28'b0, mem_be_o}, 32'h3);
            check($sformatf("sw%0d_mem_addr", c), mem_addr_o, 32'h400);
            check($sformatf("sw%0d_mem_wdata", c), mem_wdata_o, 32'h12345678);
            check($sformatf("sw%0d_stall", c), {31'b0, core_stall_o}, (c < 3) ? 32'd1 : 32'd0);
            check($sformatf("sw%0d_core_gnt", c), {31'b0, core_gnt_o}, (c == 3) ? 32'd1 : 32'd0);
            tick();
        end
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_miss_i = 1'b0;
        #2;
        check("sw_no_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        tick();

        // Core load miss, ext arrives mid-miss
        core_drive(1, 0, 4'hF, 32'h500, 32'h0);
        mem_miss_i = 1'b1;
        #2;
        check("lm0_core_gnt", {31'b0, core_gnt_o}, 32'd0);
        tick();
        ext_drive(1, 0, 4'hF, 32'h600, 32'h0);
        #2;
        check("lm1_ext_gnt", {31'b0, ext_gnt_o}, 32'd0);
        check("lm1_mem_addr", mem_addr_o, 32'h500);
        tick();
        mem_miss_i = 1'b0;
        #2;
        check("lm2_core_gnt", {31'b0, core_gnt_o}, 32'd1);
        check("lm2_ext_gnt", {31'b0, ext_gnt_o}, 32'd0);
        check("lm2_mem_addr", mem_addr_o, 32'h500);
        tick();
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_rdata_i = 32'hA5A50001;
        #2;
        check("lm3_ext_gnt", {31'b0, ext_gnt_o}, 32'd1);
        check("lm3_mem_addr", mem_addr_o, 32'h600);
        check("lm3_core_rvalid", {31'b0, core_rvalid_o}, 32'd1);
        check("lm3_core_rdata", core_rdata_o, 32'hA5A50001);
        check("lm3_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd0);
        tick();
        ext_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_rdata_i = 32'hA5A50002;
        #2;
        check("lm4_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd1);
        check("lm4_ext_rdata", ext_rdata_o, 32'hA5A50002);
        check("lm4_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        check("lm4_core_rdata", core_rdata_o, 32'd0);
        tick();

        // Reset asserted mid-miss
        core_drive(1, 0, 4'hF, 32'h700, 32'h0);
        mem_miss_i = 1'b1;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("rmiss_mem_req", {31'b0, mem_req_o}, 32'd0);
        check("rmiss_mem_addr", mem_addr_o, 32'd0);
        check("rmiss_core_gnt", {31'b0, core_gnt_o}, 32'd0);
        check("rmiss_stall", {31'b0, core_stall_o}, 32'd0);
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_miss_i = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        check("rmiss_idle_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        check("rmiss_no_rvalid_a", {31'b0, core_rvalid_o}, 32'd0);
        tick();
        check("rmiss_no_rvalid_b", {31'b0, core_rvalid_o}, 32'd0);

        // Alternating core/ext loads
        core_drive(1, 0, 4'hF, 32'h800, 32'h0);
        #2;
        check("alt0_core_gnt", {31'b0, core_gnt_o}, 32'd1);
        tick();
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        ext_drive(1, 0, 4'hF, 32'h900, 32'h0);
        mem_rdata_i = 32'h11111111;
        #2;
        check("alt1_ext_gnt", {31'b0, ext_gnt_o}, 32'd1);
        check("alt1_core_rdata", core_rdata_o, 32'h11111111);
        check("alt1_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd0);
        check("alt1_ext_rdata", ext_rdata_o, 32'd0);
        tick();
        ext_drive(0, 0, 4'h0, 32'h0, 32'h0);
        core_drive(1, 0, 4'hF, 32'h804, 32'h0);
        mem_rdata_i = 32'h22222222;
        #2;
        check("alt2_core_gnt", {31'b0, core_gnt_o}, 32'd1);
        check("alt2_ext_rdata", ext_rdata_o, 32'h22222222);
        check("alt2_core_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        check("alt2_core_rdata", core_rdata_o, 32'd0);
        tick();
        core_drive(0, 0, 4'h0, 32'h0, 32'h0);
        mem_rdata_i = 32'h33333333;
        #2;
        check("alt3_core_rdata", core_rdata_o, 32'h33333333);
        check("alt3_ext_rvalid", {31'b0, ext_rvalid_o}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
